// File: rtl/fish_game_pkg.sv
// Shared types and constants for the fishing game: phase encoding, per-level geometry, reel decode.
// Score counting in the scheduler is optional and is enabled by defining FISH_SCORE_EN.
package fish_game_pkg;

  typedef enum logic [1:0] {
    PH_WAIT   = 2'd0,
    PH_SWIM   = 2'd1,
    PH_HOOKED = 2'd2,
    PH_WIN    = 2'd3
  } phase_t;

  localparam logic [9:0] X_SPAWN     = 10'd798;
  localparam logic [9:0] X_EXIT      = 10'd144;
  localparam logic [9:0] SWIM_STEP   = 10'd2;
  localparam logic [9:0] SURFACE_Y   = 10'd106;
  localparam int         SPAWN_DELAY = 400;
  localparam logic [2:0] REEL_SLOW   = 3'd1;
  localparam logic [2:0] REEL_FAST   = 3'd4;
  localparam logic [3:0] REEL_IDLE_MAX  = 4'd8;
  localparam logic [3:0] REEL_SLOW_CODE = 4'd9;

  function automatic logic [9:0] level_y(input logic [1:0] lv);
    case (lv)
      2'd0:    level_y = 10'd470;
      2'd1:    level_y = 10'd380;
      2'd2:    level_y = 10'd290;
      default: level_y = 10'd200;
    endcase
  endfunction

  function automatic logic [9:0] catch_w(input logic [1:0] lv);
    case (lv)
      2'd0:    catch_w = 10'd15;
      2'd1:    catch_w = 10'd10;
      2'd2:    catch_w = 10'd5;
      default: catch_w = 10'd3;
    endcase
  endfunction

  function automatic logic [9:0] catch_h(input logic [1:0] lv);
    case (lv)
      2'd0:    catch_h = 10'd10;
      2'd1:    catch_h = 10'd8;
      2'd2:    catch_h = 10'd5;
      default: catch_h = 10'd3;
    endcase
  endfunction

  // Codes up to 8 leave the hook still, 9 creeps, anything above reels fast.
  function automatic logic [2:0] reel_decode(input logic [3:0] code);
    if (code > REEL_SLOW_CODE)      reel_decode = REEL_FAST;
    else if (code > REEL_IDLE_MAX)  reel_decode = REEL_SLOW;
    else                            reel_decode = 3'd0;
  endfunction

endpackage

// File: rtl/fish_spawn_timer.sv
// Counts qualifying ticks before a fish appears; done pulses on the tick that completes the delay.
module fish_spawn_timer
  import fish_game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [8:0] LAST = 9'(SPAWN_DELAY - 1);

  logic [8:0] count;

  assign done = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst)      count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 9'd1;
  end

endmodule

// File: rtl/fish_round_scheduler.sv
// Round sequencer for the fishing game: spawn delay, swim, catch, reel-up, level progression and WIN.
// Define FISH_SCORE_EN to build the saturating landed-catch counter; otherwise score reads zero.
module fish_round_scheduler
  import fish_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       move,
  input  logic       hook_up,
  input  logic [9:0] rod_x,
  input  logic [9:0] hook_y,
  input  logic [8:0] reel,
  output logic [9:0] fish_x,
  output logic [9:0] fish_y,
  output logic       fish_vis,
  output logic [1:0] level,
  output logic [1:0] phase,
  output logic [2:0] reel_step,
  output logic       win,
  output logic [7:0] score
);

  phase_t     phase_q;
  logic       spawn_en, spawn_clr, spawn_done;
  logic [2:0] step;
  logic [9:0] y_next, dy;
  logic [10:0] x_hi;
  logic       hit_x, catch_hit, landing;
  logic       unused_reel_bits;

  assign unused_reel_bits = ^reel[4:0];
  assign phase = phase_q;

  assign spawn_en  = tick && move && (phase_q == PH_WAIT);
  assign spawn_clr = (phase_q != PH_WAIT) || spawn_done;

  fish_spawn_timer u_spawn (
    .clk  (clk),
    .rst  (rst),
    .clr  (spawn_clr),
    .en   (spawn_en),
    .done (spawn_done)
  );

  // Catch window checked at 11 bits so the right edge cannot wrap past 1023.
  assign x_hi      = {1'b0, fish_x} + {1'b0, catch_w(level)};
  assign hit_x     = ({1'b0, rod_x} >= {1'b0, fish_x}) && ({1'b0, rod_x} <= x_hi);
  assign dy        = (hook_y >= fish_y) ? (hook_y - fish_y) : (fish_y - hook_y);
  assign catch_hit = hook_up && hit_x && (dy <= catch_h(level));

  assign step    = reel_decode(reel[8:5]);
  assign y_next  = (fish_y >= {7'd0, step}) ? (fish_y - {7'd0, step}) : '0;
  assign landing = (y_next < SURFACE_Y);

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q   <= PH_WAIT;
      level     <= 2'd0;
      fish_x    <= X_SPAWN;
      fish_y    <= level_y(2'd0);
      fish_vis  <= 1'b0;
      reel_step <= 3'd0;
      win       <= 1'b0;
    end else begin
      reel_step <= 3'd0;
      if (tick) begin
        unique case (phase_q)
          PH_WAIT: begin
            if (spawn_done) begin
              phase_q  <= PH_SWIM;
              fish_vis <= 1'b1;
              fish_x   <= X_SPAWN;
            end
          end
          PH_SWIM: begin
            if (catch_hit) begin
              phase_q <= PH_HOOKED;
              fish_x  <= fish_x - SWIM_STEP;
            end else if (fish_x < X_EXIT + SWIM_STEP) begin
              phase_q  <= PH_WAIT;
              fish_x   <= X_SPAWN;
              fish_vis <= 1'b0;
            end else begin
              fish_x <= fish_x - SWIM_STEP;
            end
          end
          PH_HOOKED: begin
            fish_x    <= rod_x;
            fish_y    <= y_next;
            reel_step <= step;
            if (landing) begin
              fish_vis <= 1'b0;
              if (level == 2'd3) begin
                phase_q <= PH_WIN;
                win     <= 1'b1;
              end else begin
                phase_q <= PH_WAIT;
                level   <= level + 2'd1;
                fish_y  <= level_y(level + 2'd1);
                fish_x  <= X_SPAWN;
              end
            end
          end
          PH_WIN: begin
            if (move) begin
              phase_q <= PH_WAIT;
              level   <= 2'd0;
              fish_y  <= level_y(2'd0);
              win     <= 1'b0;
            end
          end
        endcase
      end
    end
  end

`ifdef FISH_SCORE_EN
  logic [7:0] score_q;

  // Survives WIN restarts; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst)
      score_q <= '0;
    else if (tick && (phase_q == PH_HOOKED) && landing && (score_q != 8'hFF))
      score_q <= score_q + 8'd1;
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_fish_round_scheduler.sv
// Self-checking bench for fish_round_scheduler: directed round sequence with randomized side inputs vs a reference model.
module tb_fish_round_scheduler;
  import fish_game_pkg::*;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, move = 1'b0, hook_up = 1'b0;
  logic [9:0] rod_x = '0, hook_y = '0;
  logic [8:0] reel = '0;
  logic [9:0] fish_x, fish_y;
  logic       fish_vis, win;
  logic [1:0] level, phase;
  logic [2:0] reel_step;
  logic [7:0] score;

  int n_chk = 0, n_fail = 0;

  // Reference model state
  phase_t m_phase;
  int m_lvl, m_x, m_y, m_vis, m_win, m_score, m_cnt, e_step;
  int LY[4] = '{470, 380, 290, 200};
  int CW[4] = '{15, 10, 5, 3};
  int CH[4] = '{10, 8, 5, 3};

  fish_round_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .move(move), .hook_up(hook_up),
    .rod_x(rod_x), .hook_y(hook_y), .reel(reel),
    .fish_x(fish_x), .fish_y(fish_y), .fish_vis(fish_vis), .level(level),
    .phase(phase), .reel_step(reel_step), .win(win), .score(score)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("phase",     {30'd0, phase},     32'(m_phase));
    chk("fish_x",    {22'd0, fish_x},    m_x);
    chk("fish_y",    {22'd0, fish_y},    m_y);
    chk("fish_vis",  {31'd0, fish_vis},  m_vis);
    chk("level",     {30'd0, level},     m_lvl);
    chk("win",       {31'd0, win},       m_win);
    chk("score",     {24'd0, score},     m_score);
    chk("reel_step", {29'd0, reel_step}, e_step);
  endtask

  task automatic model_reset();
    m_phase = PH_WAIT; m_lvl = 0; m_x = 798; m_y = 470;
    m_vis = 0; m_win = 0; m_cnt = 0;
    m_score = 0;
  endtask

  // One clock: drive inputs, advance the model by the game rules, then compare after the edge.
  task automatic step(input bit t, input bit mv, input bit hu, input int rx, input int hy, input int rl);
    int code, d;
    bit caught;
    tick = t; move = mv; hook_up = hu;
    rod_x = 10'(rx); hook_y = 10'(hy); reel = 9'(rl);
    rx = rx % 1024; hy = hy % 1024; rl = rl % 512;
    e_step = 0;
    if (!rst) model_reset();
    else if (t) begin
      case (m_phase)
        PH_WAIT: if (mv) begin
          m_cnt++;
          if (m_cnt == 400) begin m_phase = PH_SWIM; m_vis = 1; m_x = 798; m_cnt = 0; end
        end
        PH_SWIM: begin
          d = (hy > m_y) ? hy - m_y : m_y - hy;
          caught = hu && rx >= m_x && rx <= m_x + CW[m_lvl] && d <= CH[m_lvl];
          if (caught) begin m_phase = PH_HOOKED; m_x -= 2; end
          else if (m_x < 146) begin m_x = 798; m_vis = 0; m_cnt = 0; m_phase = PH_WAIT; end
          else m_x -= 2;
        end
        PH_HOOKED: begin
          code = rl / 32;
          e_step = (code > 9) ? 4 : (code == 9) ? 1 : 0;
          m_x = rx;
          m_y = (m_y > e_step) ? m_y - e_step : 0;
          if (m_y < 106) begin
`ifdef FISH_SCORE_EN
            if (m_score < 255) m_score++;
`endif
            m_vis = 0;
            if (m_lvl == 3) begin m_phase = PH_WIN; m_win = 1; end
            else begin m_lvl++; m_y = LY[m_lvl]; m_x = 798; m_phase = PH_WAIT; end
          end
        end
        PH_WIN: if (mv) begin m_lvl = 0; m_y = 470; m_win = 0; m_phase = PH_WAIT; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom % 2), 1'($urandom % 2), $urandom % 1024, $urandom % 1024, $urandom % 512);
  endtask

  task automatic spawn();
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b1, 1'($urandom % 2), $urandom % 1024, $urandom % 1024, $urandom % 512);
      if ($urandom % 8 == 0) idle();
    end
  endtask

  task automatic swim_tick();
    step(1'b1, 1'($urandom % 2), 1'b0, $urandom % 1024, $urandom % 1024, $urandom % 512);
  endtask

  task automatic reel_out();
    int g = 0;
    while (m_phase == PH_HOOKED && g < 4000) begin
      step(1'b1, 1'($urandom % 2), 1'($urandom % 2), $urandom % 1024, $urandom % 1024,
           ($urandom_range(8, 15) << 5) | ($urandom % 32));
      if ($urandom % 6 == 0) idle();
      g++;
    end
    chk("reel_bound", {31'd0, g < 4000}, 1);
  endtask

  initial begin
    int g;
    model_reset();
    // Reset held for two clocks, then released
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 500, 470, 511);
    step(1'b1, 1'b1, 1'b1, 500, 470, 511);
    rst = 1'b1;
    chk("reset_phase", {30'd0, phase}, 32'(PH_WAIT));
    chk("reset_fish_y", {22'd0, fish_y}, 470);

    // Spawn delay: 399 moving ticks, gaps without tick or move do not count
    for (int i = 0; i < 399; i++) step(1'b1, 1'b1, 1'b0, $urandom % 1024, $urandom % 1024, $urandom % 512);
    repeat (3) step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("still_wait", {30'd0, phase}, 32'(PH_WAIT));
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    chk("spawn_vis", {31'd0, fish_vis}, 1);
    repeat (3) swim_tick();
    chk("x_after_3", {22'd0, fish_x}, 792);

    // Swim to x=500, miss just outside the window, then catch inside it
    while (m_x > 500) begin swim_tick(); if ($urandom % 5 == 0) idle(); end
    step(1'b1, 1'b0, 1'b1, m_x + 16, m_y + 5, 0);
    chk("miss_edge", {30'd0, phase}, 32'(PH_SWIM));
    step(1'b1, 1'b0, 1'b1, m_x + 10, m_y + 5, 0);
    chk("catch", {30'd0, phase}, 32'(PH_HOOKED));

    // Reel: no step without tick, 90 fast, one idle code, two slow, then land 108 -> 104
    step(1'b0, 1'b0, 1'b0, 300, 0, 10 << 5);
    for (int i = 0; i < 90; i++) step(1'b1, 1'b0, 1'b0, $urandom % 1024, 0, (10 << 5) | ($urandom % 32));
    step(1'b1, 1'b0, 1'b0, 300, 0, 8 << 5);
    step(1'b1, 1'b0, 1'b0, 300, 0, 9 << 5);
    step(1'b1, 1'b0, 1'b0, 300, 0, 9 << 5);
    chk("y_108", {22'd0, fish_y}, 108);
    step(1'b1, 1'b0, 1'b0, 300, 0, 10 << 5);
    chk("land_step", {29'd0, reel_step}, 4);
    chk("land_level", {30'd0, level}, 1);

    // Remaining levels up to WIN
    for (int lv = 1; lv < 4; lv++) begin
      spawn();
      step(1'b1, 1'b0, 1'b1, m_x + 3, m_y + 1, 0);
      reel_out();
    end
    chk("win_flag", {31'd0, win}, 1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 15 << 5);
    step(1'b1, 1'b1, 1'b0, 0, 0, 15 << 5);
    chk("restart_phase", {30'd0, phase}, 32'(PH_WAIT));

    // Fish swims off the left edge and respawns
    spawn();
    g = 0;
    while (m_phase == PH_SWIM && g < 1000) begin swim_tick(); g++; end
    chk("exit_bound", {31'd0, g < 1000}, 1);
    chk("exit_x", {22'd0, fish_x}, 798);

    // Catch on the exit tick takes priority
    spawn();
    while (m_x >= 146) swim_tick();
    step(1'b1, 1'b0, 1'b1, m_x + 3, m_y + 1, 0);
    chk("catch_over_exit", {30'd0, phase}, 32'(PH_HOOKED));
    repeat (3) step(1'b1, 1'b0, 1'b0, $urandom % 1024, 0, 12 << 5);

    // Reset mid-round
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 300, 300, 15 << 5);
    rst = 1'b1;
    chk("rst_hooked", {30'd0, phase}, 32'(PH_WAIT));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
